draw_sprite: RTL
================

Name: draw_sprite

Overview:
- Parametrised sprite overlay stage in the vga_if pixel chain; successor to the fixed-size character drawers.
- Draws one WIDTH x HEIGHT sprite from an external synchronous ROM holding FRAMES animation frames.
- Runtime position, horizontal mirror, colour-key transparency and automatic frame animation.
- Attribute updates are double-buffered and committed only at vblank start, so the picture never tears mid-frame.

Parameters:
- WIDTH, 48, sprite width in pixels (<= 2**ADDR_X_BITS)
- HEIGHT, 64, sprite height in pixels (<= 2**ADDR_Y_BITS)
- ADDR_X_BITS, 6, column field width of pixel_addr
- ADDR_Y_BITS, 6, row field width of pixel_addr
- FRAMES, 4, animation frames stored in ROM (>= 1)
- FRAME_BITS, $clog2(FRAMES) min 1, frame field width
- ANIM_DIV, 8, video frames per animation step (>= 1)
- KEY_RGB, 12'hF0F, transparent colour
- KEY_EN, 1, enables colour-key transparency
- BLANK_RGB, 12'h888, colour driven during blanking
- X0, 10, reset x position
- Y0, 10, reset y position

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- xpos  in  11  requested left edge
- ypos  in  11  requested top edge
- mirror  in  1  requested horizontal flip
- anim_en  in  1  requested auto-animation enable
- frame_sel  in  FRAME_BITS  requested static frame (used when anim_en=0)
- attr_valid  in  1  one-cycle strobe capturing xpos/ypos/mirror/anim_en/frame_sel
- attr_pending  out  1  high from capture until commit
- rgb_pixel  in  12  ROM data, valid 1 clk after pixel_addr
- pixel_addr  out  FRAME_BITS+ADDR_Y_BITS+ADDR_X_BITS  {frame, row, col}
- in  vga_if.in  -  upstream timing + rgb
- out  vga_if.out  -  downstream timing + rgb

Behaviour:
- Reset: clk and rst as stated above. All out.* = 0, pixel_addr = 0, attr_pending = 0. Active attributes = {X0, Y0, mirror 0, anim 0, frame 0}. Pending register cleared; anim divider and frame counter = 0.
- Capture: attr_valid=1 loads the pending register and sets attr_pending. A later strobe before commit overwrites the pending register (last write wins).
- Commit: on the in.vblnk rising edge (in.vblnk=1 with previous-cycle vblnk=0), active <= pending and attr_pending clears. If attr_valid coincides with the commit cycle, the strobed values are committed directly and attr_pending stays 0.
- Animation: evaluated at each vblnk rising edge.
  - If active anim_en=1: divider increments; when it reaches ANIM_DIV-1 it returns to 0 and the frame counter advances, wrapping FRAMES-1 -> 0.
  - If anim_en=0: frame = frame_sel from the commit, divider held at 0.
  - A commit that enables anim restarts from the current frame.
- Stage 1 (in+1 clk):
  - dx = in.hcount - xpos and dy = in.vcount - ypos, computed in 12-bit signed arithmetic.
  - hit = 0 <= dx < WIDTH and 0 <= dy < HEIGHT. No wrap: a sprite at xpos=1020 is clipped at the right edge.
  - col = mirror ? WIDTH-1-dx : dx. pixel_addr <= {frame, dy[ADDR_Y_BITS-1:0], col[ADDR_X_BITS-1:0]}. When hit=0, pixel_addr holds the computed value (don't care).
- Stage 2 (in+2): ROM returns rgb_pixel. Timing signals, in.rgb and hit are delayed 2 clk.
- Stage 3 (in+3), out registered:
  - If blanking: out.rgb = BLANK_RGB.
  - Else if hit and not (KEY_EN and rgb_pixel == KEY_RGB): out.rgb = rgb_pixel.
  - Else: out.rgb = delayed in.rgb.
- Latency: total latency in->out is 3 clk for all timing signals and rgb.
- Attribute timing: attributes used for a pixel are those active at stage 1. A commit therefore only affects pixels entering after the vblnk edge.
- Async reset mid-frame: outputs return to reset values immediately. The pipeline refills; the first valid output appears 3 clk after release.

Decomposition:
- vga_pkg: add sprite_attr_t packed struct {xpos, ypos, mirror, anim_en, frame}, plus constants KEY_RGB_DEFAULT and BLANK_RGB.
- Reuse the existing delay module (CLK_DEL=2) for the timing/rgb/hit pipeline.
- One sub-module: sprite_attr_ctrl. It owns the pending/active registers, the commit edge detector, the anim divider and the frame counter, and outputs the active sprite_attr_t.

Test Plan:
- Position: xpos=100, ypos=50, commit, ROM model = address pattern. Pixel (100,50) -> out.rgb = ROM[{0,0,0}] at +3 clk. Pixel (147,50) -> col 47. Pixel (148,50) -> background in.rgb.
- Mirror: mirror=1 committed. Pixel (100,50) -> addr col 47; pixel (147,50) -> col 0.
- Transparency: ROM word = 12'hF0F inside the sprite with in.rgb=12'h123 -> out 12'h123. With KEY_EN=0 -> out 12'hF0F. During blanking -> 12'h888.
- Double buffering: attr_valid with xpos=300 mid-frame -> attr_pending=1 and the drawn position stays 100 for the rest of the frame. At the vblnk edge the position becomes 300 and attr_pending=0. A strobe on the edge cycle commits directly.
- Animation: anim_en=1, ANIM_DIV=2, FRAMES=4 -> frame field sequence 0,0,1,1,2,2,3,3,0 over 9 video frames.
- Clipping/reset: xpos=1000 -> only hcount 1000..1023 drawn, no wrap to x=0. Assert rst low mid-line -> all outputs 0 immediately; position returns to X0,Y0 after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the vga_if pixel chain.
package vga_pkg;

  // Wide enough for any animation strip the sprite stages are built with.
  localparam int SPRITE_FRAME_W = 8;

  localparam logic [11:0] KEY_RGB_DEFAULT = 12'hF0F;
  localparam logic [11:0] BLANK_RGB       = 12'h888;

  // Sprite attributes; frame is the static frame selection on input and the
  // live animation frame on the active output of sprite_attr_ctrl.
  typedef struct packed {
    logic [10:0]               xpos;
    logic [10:0]               ypos;
    logic                      mirror;
    logic                      anim_en;
    logic [SPRITE_FRAME_W-1:0] frame;
  } sprite_attr_t;

endpackage

// File: rtl/vga_if.sv
// Pixel-chain bundle: raster timing plus 12-bit colour.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/delay.sv
// Fixed-length register pipeline used to align side-band data with ROM reads.
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [CLK_DEL];

  // Shift din through CLK_DEL registers; cleared by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CLK_DEL; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/sprite_attr_ctrl.sv
// Double-buffered sprite attributes with vblank-start commit and frame animation.
module sprite_attr_ctrl
  import vga_pkg::*;
#(
  parameter int          FRAMES     = 4,
  parameter int          FRAME_BITS = 2,
  parameter int          ANIM_DIV   = 8,
  parameter logic [10:0] X0         = 11'd10,
  parameter logic [10:0] Y0         = 11'd10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [10:0]           xpos,
  input  logic [10:0]           ypos,
  input  logic                  mirror,
  input  logic                  anim_en,
  input  logic [FRAME_BITS-1:0] frame_sel,
  input  logic                  attr_valid,
  input  logic                  vblnk,
  output logic                  attr_pending,
  output sprite_attr_t          active
);

  localparam int DIV_BITS = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  sprite_attr_t          req;
  sprite_attr_t          pend_q;
  sprite_attr_t          act_q;
  sprite_attr_t          next_act;
  sprite_attr_t          eff;
  logic                  pending_q;
  logic                  vblnk_q;
  logic                  commit_edge;
  logic                  do_commit;
  logic [DIV_BITS-1:0]   div_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  ctrl_unused;

  // Decode the strobe, the vblank rising edge and the attributes that win it.
  always_comb begin
    req         = '{xpos: xpos, ypos: ypos, mirror: mirror, anim_en: anim_en,
                    frame: SPRITE_FRAME_W'(frame_sel)};
    commit_edge = vblnk & ~vblnk_q;
    do_commit   = commit_edge & (attr_valid | pending_q);
    // A strobe on the edge cycle bypasses the pending register.
    next_act    = attr_valid ? req : pend_q;
    eff         = do_commit ? next_act : act_q;
  end

  // Pending/active registers, commit, animation divider and frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q    <= '0;
      act_q     <= '{xpos: X0, ypos: Y0, mirror: 1'b0, anim_en: 1'b0, frame: '0};
      pending_q <= 1'b0;
      vblnk_q   <= 1'b0;
      div_q     <= '0;
      frame_q   <= '0;
    end else begin
      vblnk_q <= vblnk;
      if (commit_edge) begin
        if (do_commit) act_q <= next_act;
        pending_q <= 1'b0;
        if (eff.anim_en) begin
          if (do_commit && !act_q.anim_en) begin
            // Freshly enabled: start counting from the frame already shown.
            div_q <= '0;
          end else if (div_q == DIV_BITS'(ANIM_DIV - 1)) begin
            div_q   <= '0;
            frame_q <= (frame_q == FRAME_BITS'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end else begin
          div_q   <= '0;
          frame_q <= eff.frame[FRAME_BITS-1:0];
        end
      end else if (attr_valid) begin
        pend_q    <= req;
        pending_q <= 1'b1;
      end
    end
  end

  // Publish the active attributes with the live frame number.
  always_comb begin
    active       = act_q;
    active.frame = SPRITE_FRAME_W'(frame_q);
  end

  assign attr_pending = pending_q;
  assign ctrl_unused  = ^eff.frame;

endmodule

// File: rtl/draw_sprite.sv
// Sprite overlay stage: ROM address in stage 1, ROM data in stage 2, mux in stage 3.
module draw_sprite #(
  parameter int          WIDTH       = 48,
  parameter int          HEIGHT      = 64,
  parameter int          ADDR_X_BITS = 6,
  parameter int          ADDR_Y_BITS = 6,
  parameter int          FRAMES      = 4,
  parameter int          FRAME_BITS  = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  parameter int          ANIM_DIV    = 8,
  parameter logic [11:0] KEY_RGB     = vga_pkg::KEY_RGB_DEFAULT,
  parameter bit          KEY_EN      = 1'b1,
  parameter logic [11:0] BLANK_RGB   = vga_pkg::BLANK_RGB,
  parameter logic [10:0] X0          = 11'd10,
  parameter logic [10:0] Y0          = 11'd10
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [10:0]                                 xpos,
  input  logic [10:0]                                 ypos,
  input  logic                                        mirror,
  input  logic                                        anim_en,
  input  logic [FRAME_BITS-1:0]                       frame_sel,
  input  logic                                        attr_valid,
  output logic                                        attr_pending,
  input  logic [11:0]                                 rgb_pixel,
  output logic [FRAME_BITS+ADDR_Y_BITS+ADDR_X_BITS-1:0] pixel_addr,
  vga_if.in                                           in,
  vga_if.out                                          out
);

  vga_pkg::sprite_attr_t attr;

  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic [11:0]        col;
  logic               hit;
  logic               attr_unused;

  logic [38:0] pipe_in;
  logic [38:0] pipe_out;
  logic [10:0] d_vcount;
  logic        d_vsync;
  logic        d_vblnk;
  logic [10:0] d_hcount;
  logic        d_hsync;
  logic        d_hblnk;
  logic [11:0] d_rgb;
  logic        d_hit;
  logic        keyed;
  logic [11:0] rgb_nxt;

  logic [10:0] vcount_q;
  logic        vsync_q;
  logic        vblnk_q;
  logic [10:0] hcount_q;
  logic        hsync_q;
  logic        hblnk_q;
  logic [11:0] rgb_q;

  sprite_attr_ctrl #(
    .FRAMES     (FRAMES),
    .FRAME_BITS (FRAME_BITS),
    .ANIM_DIV   (ANIM_DIV),
    .X0         (X0),
    .Y0         (Y0)
  ) u_attr (
    .clk          (clk),
    .rst          (rst),
    .xpos         (xpos),
    .ypos         (ypos),
    .mirror       (mirror),
    .anim_en      (anim_en),
    .frame_sel    (frame_sel),
    .attr_valid   (attr_valid),
    .vblnk        (in.vblnk),
    .attr_pending (attr_pending),
    .active       (attr)
  );

  // Sprite-relative coordinates; negative offsets clip instead of wrapping.
  always_comb begin
    dx  = $signed({1'b0, in.hcount}) - $signed({1'b0, attr.xpos});
    dy  = $signed({1'b0, in.vcount}) - $signed({1'b0, attr.ypos});
    hit = ~dx[11] & (dx[10:0] < 11'(WIDTH)) & ~dy[11] & (dy[10:0] < 11'(HEIGHT));
    col = attr.mirror ? (12'(WIDTH - 1) - dx) : dx;
  end

  // Stage 1: register the ROM address so data returns alongside the delayed pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pixel_addr <= '0;
    else      pixel_addr <= {attr.frame[FRAME_BITS-1:0], dy[ADDR_Y_BITS-1:0],
                             col[ADDR_X_BITS-1:0]};
  end

  assign pipe_in = {in.vcount, in.vsync, in.vblnk, in.hcount, in.hsync, in.hblnk,
                    in.rgb, hit};

  delay #(
    .WIDTH   (39),
    .CLK_DEL (2)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (pipe_in),
    .dout (pipe_out)
  );

  assign {d_vcount, d_vsync, d_vblnk, d_hcount, d_hsync, d_hblnk, d_rgb, d_hit} = pipe_out;

  // Colour select: blanking first, then opaque sprite pixel, else background.
  always_comb begin
    keyed   = KEY_EN && (rgb_pixel == KEY_RGB);
    rgb_nxt = d_rgb;
    if (d_vblnk || d_hblnk)  rgb_nxt = BLANK_RGB;
    else if (d_hit && !keyed) rgb_nxt = rgb_pixel;
  end

  // Stage 3: registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vcount_q <= '0;
      vsync_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      hcount_q <= '0;
      hsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      rgb_q    <= '0;
    end else begin
      vcount_q <= d_vcount;
      vsync_q  <= d_vsync;
      vblnk_q  <= d_vblnk;
      hcount_q <= d_hcount;
      hsync_q  <= d_hsync;
      hblnk_q  <= d_hblnk;
      rgb_q    <= rgb_nxt;
    end
  end

  assign out.vcount = vcount_q;
  assign out.vsync  = vsync_q;
  assign out.vblnk  = vblnk_q;
  assign out.hcount = hcount_q;
  assign out.hsync  = hsync_q;
  assign out.hblnk  = hblnk_q;
  assign out.rgb    = rgb_q;

  // The stage only needs position, mirror and the low frame bits.
  assign attr_unused = ^{attr.anim_en, attr.frame};

endmodule
